// File: rtl/seqdet_rr_scheduler.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : seqdet_rr_scheduler                                        |
// | Description : Round-robin scheduler that shares one serial Mealy         |
// |               pattern-detector engine among NUM_REQ bit-stream           |
// |               requesters. Each grant is a burst of up to BURST_LEN bits. |
// |               The detector is cleared before every burst. Detector hits  |
// |               are attributed to the owner and counted per requester.     |
// |               Counters saturate at their maximum value.                  |
// | Optional    : SEQDET_TIMEOUT_EN - force release of a stalled owner after |
// |               TIMEOUT_CYC cycles without a transfer.                     |
// | Ports       : clk, reset (async, active-high)                            |
// |               req/bit_valid/bit_data -> bit_ready  : requester channels  |
// |               det_clr/det_step/det_x <- det_y      : shared detector     |
// |               grant, busy, hit, hit_id, timeout    : status              |
// |               cnt_clr, rd_sel -> rd_count          : hit counter access  |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module seqdet_rr_scheduler #(
    parameter int NUM_REQ     = 4,
    parameter int BURST_LEN   = 16,
    parameter int CNT_W       = 8,
    parameter int TIMEOUT_CYC = 32
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NUM_REQ-1:0]         req,
    input  logic [NUM_REQ-1:0]         bit_valid,
    input  logic [NUM_REQ-1:0]         bit_data,
    output logic [NUM_REQ-1:0]         bit_ready,
    output logic                       det_clr,
    output logic                       det_step,
    output logic                       det_x,
    input  logic                       det_y,
    output logic [NUM_REQ-1:0]         grant,
    output logic                       busy,
    output logic                       hit,
    output logic [$clog2(NUM_REQ)-1:0] hit_id,
    input  logic                       cnt_clr,
    input  logic [$clog2(NUM_REQ)-1:0] rd_sel,
    output logic [CNT_W-1:0]           rd_count,
    output logic                       timeout
);

    localparam int C_IDW = $clog2(NUM_REQ);
    localparam int C_BCW = $clog2(BURST_LEN + 1);
    localparam logic [CNT_W-1:0] C_CNT_MAX = '1;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_CLEAR   = 2'd1,
        S_STREAM  = 2'd2,
        S_RELEASE = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [NUM_REQ-1:0] grant_q, grant_d;
    logic [C_IDW-1:0]   owner_q, owner_d;
    logic [C_IDW-1:0]   ptr_q, ptr_d;
    logic [C_BCW-1:0]   bit_cnt_q, bit_cnt_d;
    logic               hit_q, hit_d;
    logic [C_IDW-1:0]   hit_id_q, hit_id_d;
    logic [CNT_W-1:0]   cnt_q [NUM_REQ];
    logic [CNT_W-1:0]   cnt_d [NUM_REQ];

    logic               xfer;
    logic               idle_expired;
    logic               arb_found;
    logic [C_IDW-1:0]   arb_idx;
    logic [C_IDW:0]     cand;

    // A bit moves only while streaming and the owner offers one; bit_ready
    // is unconditionally high for the owner in STREAM.
    assign xfer = (state_q == S_STREAM) && bit_valid[owner_q];

    // Rotating priority search: start at ptr_q and wrap. The extra MSB on
    // cand lets ptr+i exceed NUM_REQ-1 before the wrap subtraction.
    always_comb begin
        arb_found = 1'b0;
        arb_idx   = '0;
        cand      = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand = {1'b0, ptr_q} + (C_IDW+1)'(i);
            if (cand >= (C_IDW+1)'(NUM_REQ)) begin
                cand = cand - (C_IDW+1)'(NUM_REQ);
            end
            if (!arb_found && req[cand[C_IDW-1:0]]) begin
                arb_found = 1'b1;
                arb_idx   = cand[C_IDW-1:0];
            end
        end
    end

`ifdef SEQDET_TIMEOUT_EN
    localparam int C_TW = $clog2(TIMEOUT_CYC + 1);

    logic [C_TW-1:0] idle_cnt_q, idle_cnt_d;
    logic            timeout_q;

    always_comb begin
        idle_cnt_d = idle_cnt_q;
        if (state_q == S_CLEAR) begin
            idle_cnt_d = '0;
        end else if (state_q == S_STREAM) begin
            idle_cnt_d = xfer ? '0 : idle_cnt_q + 1'b1;
        end
    end

    // A dropped request releases through the normal path, so a timeout is
    // only flagged while the owner is still asking for the engine.
    assign idle_expired = (state_q == S_STREAM) && !xfer && req[owner_q] &&
                          (idle_cnt_d == C_TW'(TIMEOUT_CYC));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idle_cnt_q <= '0;
            timeout_q  <= 1'b0;
        end else begin
            idle_cnt_q <= idle_cnt_d;
            timeout_q  <= idle_expired;
        end
    end

    assign timeout = timeout_q;
`else
    logic unused_timeout_cfg;

    assign unused_timeout_cfg = (TIMEOUT_CYC != 0);
    assign idle_expired       = 1'b0;
    assign timeout            = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        owner_d   = owner_q;
        ptr_d     = ptr_q;
        bit_cnt_d = bit_cnt_q;
        hit_d     = 1'b0;
        hit_id_d  = hit_id_q;
        cnt_d     = cnt_q;
        bit_ready = '0;
        det_clr   = 1'b0;
        det_step  = 1'b0;
        det_x     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (arb_found) begin
                    grant_d = NUM_REQ'(1) << arb_idx;
                    owner_d = arb_idx;
                    state_d = S_CLEAR;
                end
            end
            S_CLEAR: begin
                det_clr   = 1'b1;
                bit_cnt_d = '0;
                state_d   = S_STREAM;
            end
            S_STREAM: begin
                bit_ready = grant_q;
                det_step  = xfer;
                det_x     = xfer & bit_data[owner_q];
                if (xfer) begin
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    if (det_y) begin
                        hit_d    = 1'b1;
                        hit_id_d = owner_q;
                        if (cnt_q[owner_q] != C_CNT_MAX) begin
                            cnt_d[owner_q] = cnt_q[owner_q] + 1'b1;
                        end
                    end
                    if (bit_cnt_q == C_BCW'(BURST_LEN - 1)) begin
                        state_d = S_RELEASE;
                        grant_d = '0;
                    end
                end else if (!req[owner_q] || idle_expired) begin
                    state_d = S_RELEASE;
                    grant_d = '0;
                end
            end
            S_RELEASE: begin
                ptr_d   = (owner_q == C_IDW'(NUM_REQ - 1)) ? '0 : owner_q + 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // Clear takes priority over a same-cycle increment; the hit pulse
        // itself is unaffected.
        if (cnt_clr) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                cnt_d[i] = '0;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            grant_q   <= '0;
            owner_q   <= '0;
            ptr_q     <= '0;
            bit_cnt_q <= '0;
            hit_q     <= 1'b0;
            hit_id_q  <= '0;
            for (int i = 0; i < NUM_REQ; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            owner_q   <= owner_d;
            ptr_q     <= ptr_d;
            bit_cnt_q <= bit_cnt_d;
            hit_q     <= hit_d;
            hit_id_q  <= hit_id_d;
            cnt_q     <= cnt_d;
        end
    end

    always_comb begin
        rd_count = '0;
        if ({1'b0, rd_sel} < (C_IDW+1)'(NUM_REQ)) begin
            rd_count = cnt_q[rd_sel];
        end
    end

    assign grant  = grant_q;
    assign busy   = (state_q != S_IDLE);
    assign hit    = hit_q;
    assign hit_id = hit_id_q;

endmodule
`default_nettype wire

// File: tb/tb_seqdet_rr_scheduler.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_seqdet_rr_scheduler                                     |
// | Description : Self-checking bench for seqdet_rr_scheduler. Provides an   |
// |               overlapping "1011" Mealy detector on det_*. Checks grants, |
// |               bursts, hit attribution and counters against a reference.  |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_seqdet_rr_scheduler;

    localparam int NUM_REQ     = 4;
    localparam int BURST_LEN   = 16;
    localparam int CNT_W       = 2;
    localparam int TIMEOUT_CYC = 32;

    logic              clk;
    logic              reset;
    logic [3:0]        req;
    logic [3:0]        bit_valid;
    logic [3:0]        bit_data;
    logic [3:0]        bit_ready;
    logic              det_clr;
    logic              det_step;
    logic              det_x;
    logic              det_y;
    logic [3:0]        grant;
    logic              busy;
    logic              hit;
    logic [1:0]        hit_id;
    logic              cnt_clr;
    logic [1:0]        rd_sel;
    logic [CNT_W-1:0]  rd_count;
    logic              timeout;

    seqdet_rr_scheduler #(
        .NUM_REQ     (NUM_REQ),
        .BURST_LEN   (BURST_LEN),
        .CNT_W       (CNT_W),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .bit_valid (bit_valid),
        .bit_data  (bit_data),
        .bit_ready (bit_ready),
        .det_clr   (det_clr),
        .det_step  (det_step),
        .det_x     (det_x),
        .det_y     (det_y),
        .grant     (grant),
        .busy      (busy),
        .hit       (hit),
        .hit_id    (hit_id),
        .cnt_clr   (cnt_clr),
        .rd_sel    (rd_sel),
        .rd_count  (rd_count),
        .timeout   (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // External detector for "1011", overlapping matches allowed.
    logic [1:0] dst;

    function automatic logic [1:0] dnext(input logic [1:0] s, input logic x);
        case (s)
            2'd0:    return x ? 2'd1 : 2'd0;
            2'd1:    return x ? 2'd1 : 2'd2;
            2'd2:    return x ? 2'd3 : 2'd0;
            default: return x ? 2'd1 : 2'd2;
        endcase
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset)         dst <= 2'd0;
        else if (det_clr)  dst <= 2'd0;
        else if (det_step) dst <= dnext(dst, det_x);
    end

    assign det_y = det_step && (dst == 2'd3) && det_x;

    typedef struct {
        int id;
        int cyc;
    } hexp_t;

    typedef struct {
        int          id;
        logic [15:0] pat;
        int          nb;
        int          exp_hits;
        int          exp_cnt;
    } vec_t;

    hexp_t      hq[$];
    hexp_t      he;
    vec_t       vt[6];
    int         n_vec = 0;
    int         n_err = 0;
    int         hits_seen = 0;
    bit         to_seen = 1'b0;
    int         exp_cnt[4];
    logic [3:0] sh;
    int         nbits;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            if (timeout) to_seen = 1'b1;
            chk("step_eq_xfer", 32'(det_step), 32'(|(bit_ready & bit_valid)));
            chk("ready_within_grant", 32'(bit_ready & ~grant), 32'd0);
            if (!det_step) chk("det_x_idle", 32'(det_x), 32'd0);
            if (hit) begin
                hits_seen++;
                if (hq.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL hit_unexpected: hit_id=%0d at cycle %0d, no hit expected", hit_id, cyc);
                end else begin
                    he = hq.pop_front();
                    chk("hit_id", 32'(hit_id), he.id);
                    chk("hit_cycle", cyc, he.cyc);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_counters();
        for (int i = 0; i < NUM_REQ; i++) begin
            rd_sel = 2'(i);
            #1;
            chk($sformatf("rd_count[%0d]", i), 32'(rd_count), exp_cnt[i]);
        end
        tick();
    endtask

    // Offer one bit and wait (bounded) for its transfer. When model is set,
    // the expected hit/counter effect is derived from the burst's bit history.
    task automatic send_bit(input int g, input logic b, input bit clr, input bit first, input bit model);
        int w;
        w = 0;
        bit_valid[g] = 1'b1;
        bit_data[g]  = b;
        cnt_clr      = clr;
        #1;
        while (!bit_ready[g] && w < 20) begin
            @(posedge clk);
            #2;
            w++;
        end
        chk("bit_ready_seen", 32'(bit_ready[g]), 32'd1);
        if (first) chk("first_accept_wait", w, 32'd1);
        chk("det_step_on_xfer", 32'(det_step), 32'd1);
        chk("det_x_bit", 32'(det_x), 32'(b));
        if (model) begin
            sh = {sh[2:0], b};
            nbits++;
            if (nbits >= 4 && sh == 4'b1011) begin
                hq.push_back('{id: g, cyc: cyc + 1});
                if (exp_cnt[g] < (1 << CNT_W) - 1) exp_cnt[g]++;
            end
            if (clr) begin
                for (int i = 0; i < NUM_REQ; i++) exp_cnt[i] = 0;
            end
        end
        tick();
        bit_valid[g] = 1'b0;
        cnt_clr      = 1'b0;
    endtask

    task automatic drive_burst(input int g, input logic [15:0] pat, input int nb,
                               input int clr_at, input logic [3:0] extra);
        int t;
        sh    = 4'b0;
        nbits = 0;
        req   = req | extra;
        req[g] = 1'b1;
        t = 0;
        while (grant == 4'b0 && t < 20) begin
            tick();
            t++;
        end
        chk("grant_owner", 32'(grant), 32'(4'b0001 << g));
        chk("det_clr_with_grant", 32'(det_clr), 32'd1);
        chk("busy_in_burst", 32'(busy), 32'd1);
        req = req & ~extra;
        for (int k = 0; k < nb; k++) begin
            send_bit(g, pat[nb-1-k], (k == clr_at), (k == 0), 1'b1);
        end
        req[g] = 1'b0;
        t = 0;
        while (grant != 4'b0 && t < 5) begin
            tick();
            t++;
        end
        chk("released", 32'(grant), 32'd0);
        tick();
        tick();
        chk("hits_outstanding", hq.size(), 32'd0);
        hq.delete();
        chk("no_spurious_timeout", 32'(to_seen), 32'd0);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        int t;
        int gap;
        int steps;
        int h0;

        vt[0] = '{id: 0, pat: 16'b1011,             nb: 4,  exp_hits: 1, exp_cnt: 1};
        vt[1] = '{id: 1, pat: 16'b1011011,          nb: 7,  exp_hits: 2, exp_cnt: 2};
        vt[2] = '{id: 0, pat: 16'b1011011011011011, nb: 16, exp_hits: 5, exp_cnt: 3};
        vt[3] = '{id: 2, pat: 16'b00001111,         nb: 8,  exp_hits: 0, exp_cnt: 0};
        vt[4] = '{id: 3, pat: 16'b11011,            nb: 5,  exp_hits: 1, exp_cnt: 1};
        vt[5] = '{id: 2, pat: 16'b101011,           nb: 6,  exp_hits: 1, exp_cnt: 1};

        for (int i = 0; i < NUM_REQ; i++) exp_cnt[i] = 0;
        sh        = 4'b0;
        nbits     = 0;
        reset     = 1'b1;
        req       = 4'b0;
        bit_valid = 4'b0;
        bit_data  = 4'b0;
        cnt_clr   = 1'b0;
        rd_sel    = 2'd0;
        repeat (3) @(posedge clk);
        #3;
        reset = 1'b0;
        tick();

        // Reset state
        chk("rst_grant", 32'(grant), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_bit_ready", 32'(bit_ready), 32'd0);
        chk("rst_det_clr", 32'(det_clr), 32'd0);
        chk("rst_det_step", 32'(det_step), 32'd0);
        chk("rst_det_x", 32'(det_x), 32'd0);
        chk("rst_hit", 32'(hit), 32'd0);
        chk("rst_hit_id", 32'(hit_id), 32'd0);
        chk("rst_timeout", 32'(timeout), 32'd0);
        check_counters();

        // All requesters active: rotation 0,1,2,3,0 with 16-bit bursts
        req       = 4'hF;
        bit_valid = 4'hF;
        bit_data  = 4'h0;
        for (int b = 0; b < 5; b++) begin
            gap = 0;
            while (grant == 4'b0 && gap < 20) begin
                tick();
                gap++;
            end
            chk("rr_grant", 32'(grant), 32'(4'b0001 << (b % 4)));
            if (b > 0) chk("rr_gap", gap, 32'd2);
            steps = 0;
            t = 0;
            while (grant == (4'b0001 << (b % 4)) && t < 40) begin
                if (det_step) steps++;
                tick();
                t++;
            end
            chk("rr_burst_steps", steps, 32'd16);
            if (b == 4) begin
                req       = 4'b0;
                bit_valid = 4'b0;
            end
        end
        tick();
        tick();
        chk("rr_idle_after", 32'(busy), 32'd0);
        chk("rr_no_hits", hits_seen, 32'd0);

        // Single-requester bursts from the vector table
        for (int i = 0; i < 6; i++) begin
            h0 = hits_seen;
            drive_burst(vt[i].id, vt[i].pat, vt[i].nb, -1, 4'b0);
            chk($sformatf("burst_hits[%0d]", i), hits_seen - h0, vt[i].exp_hits);
            rd_sel = 2'(vt[i].id);
            #1;
            chk($sformatf("table_count[%0d]", i), 32'(rd_count), vt[i].exp_cnt);
            check_counters();
        end

        // Pattern split across grants is not detected; pointer lands on 3
        h0 = hits_seen;
        drive_burst(2, 16'b101, 3, -1, 4'b0);
        drive_burst(3, 16'b1, 1, -1, 4'b0001);
        chk("split_no_hit", hits_seen - h0, 32'd0);
        check_counters();

        // Counter clear coincident with the second overlapping detection
        h0 = hits_seen;
        drive_burst(1, 16'b1011011, 7, 6, 4'b0);
        chk("clr_hits", hits_seen - h0, 32'd2);
        check_counters();

        // Asynchronous reset in the middle of a burst with a hit pending
        sh    = 4'b0;
        nbits = 0;
        req   = 4'b0001;
        t = 0;
        while (grant == 4'b0 && t < 20) begin
            tick();
            t++;
        end
        chk("rstmid_grant", 32'(grant), 32'd1);
        send_bit(0, 1'b1, 1'b0, 1'b1, 1'b0);
        send_bit(0, 1'b0, 1'b0, 1'b0, 1'b0);
        send_bit(0, 1'b1, 1'b0, 1'b0, 1'b0);
        bit_valid[0] = 1'b1;
        bit_data[0]  = 1'b1;
        #2;
        reset = 1'b1;
        #1;
        chk("rstmid_grant_zero", 32'(grant), 32'd0);
        chk("rstmid_busy_zero", 32'(busy), 32'd0);
        chk("rstmid_ready_zero", 32'(bit_ready), 32'd0);
        req       = 4'b0;
        bit_valid = 4'b0;
        bit_data  = 4'b0;
        tick();
        chk("rstmid_hit_dropped", 32'(hit), 32'd0);
        #2;
        reset = 1'b0;
        tick();
        chk("rstmid_hit_after", 32'(hit), 32'd0);
        chk("rstmid_idle", 32'(busy), 32'd0);
        for (int i = 0; i < NUM_REQ; i++) exp_cnt[i] = 0;
        check_counters();

`ifdef SEQDET_TIMEOUT_EN
        // Stalled owner is forced out after TIMEOUT_CYC idle cycles
        req       = 4'b0011;
        bit_valid = 4'b0;
        t = 0;
        while (grant == 4'b0 && t < 20) begin
            tick();
            t++;
        end
        chk("to_grant", 32'(grant), 32'd1);
        t = 0;
        while (grant == 4'b0001 && t < 60) begin
            tick();
            t++;
        end
        chk("to_hold_cycles", t, 32'd33);
        chk("to_pulse", 32'(timeout), 32'd1);
        t = 0;
        while (grant == 4'b0 && t < 20) begin
            tick();
            t++;
        end
        chk("to_next_grant", 32'(grant), 32'd2);
        chk("to_pulse_gone", 32'(timeout), 32'd0);
        req = 4'b0;
        t = 0;
        while (busy && t < 10) begin
            tick();
            t++;
        end
        chk("to_idle", 32'(busy), 32'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
